// File: rtl/fpu_pkg.sv
// Shared FPU definitions (multiplier and divider): IEEE-754 single constants,
// the unpacked operand record and classification helpers.
package fpu_pkg;

  localparam int          FP_EXP_BIAS = 127;
  localparam logic [31:0] FP_QNAN     = 32'hFFC00000;
  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

  // e is a two's-complement 10-bit exponent; m carries the hidden bit at [23]
  typedef struct packed {
    logic        s;
    logic [9:0]  e;
    logic [23:0] m;
  } fp_unpacked_t;

  // Raw split: hidden bit left clear, exponent unbiased
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
    fp_unpacked_t u;
    u.s = v[31];
    u.e = {2'b00, v[30:23]} - 10'(FP_EXP_BIAS);
    u.m = {1'b0, v[22:0]};
    return u;
  endfunction

  function automatic logic fp_is_nan(input fp_unpacked_t u);
    return (u.e == 10'd128) && (u.m != 24'd0);
  endfunction

  function automatic logic fp_is_inf(input fp_unpacked_t u);
    return (u.e == 10'd128) && (u.m == 24'd0);
  endfunction

  function automatic logic fp_is_zero(input fp_unpacked_t u);
    return ($signed(u.e) == -10'sd127) && (u.m == 24'd0);
  endfunction

endpackage

// File: rtl/mant_mul.sv
// 24x24 -> 48 unsigned mantissa multiplier with start/done.
// MULTIPLIER_SEQ_MUL_EN selects a 24-cycle shift-add loop; otherwise a single
// '*' operator whose done follows start in the same cycle.
module mant_mul (
`ifdef MULTIPLIER_SEQ_MUL_EN
  input  logic        clk,
  input  logic        reset_i,
`endif
  input  logic        start,
  input  logic [23:0] a_m,
  input  logic [23:0] b_m,
  output logic        done,
  output logic [47:0] product
);

`ifdef MULTIPLIER_SEQ_MUL_EN
  logic [47:0] acc;
  logic [4:0]  cnt;
  logic [47:0] partial;

  // Partial product for the multiplier bit selected by the iteration count
  always_comb begin
    partial = '0;
    if (b_m[cnt]) partial = {24'd0, a_m} << cnt;
  end

  // Last iteration folds its partial product in combinationally
  assign product = acc + partial;
  assign done    = start && (cnt == 5'd23);

  // Accumulate one bit per cycle while start is held; rearm after the last bit
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      if (cnt == 5'd23) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= product;
        cnt <= cnt + 5'd1;
      end
    end
  end
`else
  assign product = 48'(a_m) * 48'(b_m);
  assign done    = start;
`endif

endmodule

// File: rtl/multiplier.sv
// IEEE-754 single-precision multiplier, multi-cycle FSM with strobe handshake.
// Handles NaN/inf/zero, denormals, round-to-nearest-even, overflow and
// gradual underflow. Build option: MULTIPLIER_SEQ_MUL_EN (shift-add mantissa
// multiply inside mant_mul).
module multiplier
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] a_value_i,
  input  logic [31:0] b_value_i,
  input  logic        exec_strobe_i,
  output logic [31:0] z_value_o,
  output logic        done_strobe_o
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL_CASES, NORMALIZE_A, NORMALIZE_B, MULTIPLY,
    MULTIPLY_DONE, NORMALIZE_0, NORMALIZE_1, ROUND, PACK, DONE
  } state_t;

  state_t       state;
  logic [31:0]  a_q, b_q;
  fp_unpacked_t a_u, b_u, z_u;
  logic [47:0]  product_q;
  logic         guard, round_bit, sticky;

  logic         mul_start, mul_done;
  logic [47:0]  mul_product;

  assign mul_start = (state == MULTIPLY);

  mant_mul u_mant_mul (
`ifdef MULTIPLIER_SEQ_MUL_EN
    .clk     (clk),
    .reset_i (reset_i),
`endif
    .start   (mul_start),
    .a_m     (a_u.m),
    .b_m     (b_u.m),
    .done    (mul_done),
    .product (mul_product)
  );

  // Main sequencer: operand capture, special values, normalize, multiply, round, pack
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state         <= IDLE;
      done_strobe_o <= 1'b0;
      z_value_o     <= '0;
      a_q           <= '0;
      b_q           <= '0;
      a_u           <= '0;
      b_u           <= '0;
      z_u           <= '0;
      product_q     <= '0;
      guard         <= 1'b0;
      round_bit     <= 1'b0;
      sticky        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_strobe_o <= 1'b0;
          if (exec_strobe_i) begin
            a_q   <= a_value_i;
            b_q   <= b_value_i;
            state <= UNPACK;
          end
        end

        UNPACK: begin
          a_u   <= fp_unpack(a_q);
          b_u   <= fp_unpack(b_q);
          state <= SPECIAL_CASES;
        end

        SPECIAL_CASES: begin
          if (fp_is_nan(a_u) || fp_is_nan(b_u)) begin
            z_value_o <= FP_QNAN;
            state     <= DONE;
          end else if ((fp_is_inf(a_u) && fp_is_zero(b_u)) ||
                       (fp_is_inf(b_u) && fp_is_zero(a_u))) begin
            z_value_o <= FP_QNAN;
            state     <= DONE;
          end else if (fp_is_inf(a_u) || fp_is_inf(b_u)) begin
            z_value_o <= {a_u.s ^ b_u.s, FP_EXP_MAX, 23'd0};
            state     <= DONE;
          end else if (fp_is_zero(a_u) || fp_is_zero(b_u)) begin
            z_value_o <= {a_u.s ^ b_u.s, 31'd0};
            state     <= DONE;
          end else begin
            // Denormals take the minimum exponent; normals get the hidden bit
            if ($signed(a_u.e) == -10'sd127) a_u.e <= -10'sd126;
            else                              a_u.m[23] <= 1'b1;
            if ($signed(b_u.e) == -10'sd127) b_u.e <= -10'sd126;
            else                              b_u.m[23] <= 1'b1;
            state <= NORMALIZE_A;
          end
        end

        NORMALIZE_A: begin
          if (a_u.m[23]) state <= NORMALIZE_B;
          else begin
            a_u.m <= a_u.m << 1;
            a_u.e <= a_u.e - 10'd1;
          end
        end

        NORMALIZE_B: begin
          if (b_u.m[23]) state <= MULTIPLY;
          else begin
            b_u.m <= b_u.m << 1;
            b_u.e <= b_u.e - 10'd1;
          end
        end

        MULTIPLY: begin
          z_u.s <= a_u.s ^ b_u.s;
          z_u.e <= a_u.e + b_u.e + 10'd1;
          if (mul_done) begin
            product_q <= mul_product;
            state     <= MULTIPLY_DONE;
          end
        end

        MULTIPLY_DONE: begin
          z_u.m     <= product_q[47:24];
          guard     <= product_q[23];
          round_bit <= product_q[22];
          sticky    <= |product_q[21:0];
          state     <= NORMALIZE_0;
        end

        NORMALIZE_0: begin
          if (!z_u.m[23] && ($signed(z_u.e) > -10'sd126)) begin
            z_u.e     <= z_u.e - 10'd1;
            z_u.m     <= {z_u.m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
          end else begin
            state <= NORMALIZE_1;
          end
        end

        NORMALIZE_1: begin
          if ($signed(z_u.e) < -10'sd126) begin
            z_u.e     <= z_u.e + 10'd1;
            z_u.m     <= z_u.m >> 1;
            guard     <= z_u.m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end else begin
            state <= ROUND;
          end
        end

        ROUND: begin
          // Ties go to the even mantissa
          if (guard && (round_bit || sticky || z_u.m[0])) begin
            z_u.m <= z_u.m + 24'd1;
            if (z_u.m == 24'hFFFFFF) z_u.e <= z_u.e + 10'd1;
          end
          state <= PACK;
        end

        PACK: begin
          z_value_o <= {z_u.s, z_u.e[7:0] + 8'(FP_EXP_BIAS), z_u.m[22:0]};
          if (($signed(z_u.e) == -10'sd126) && !z_u.m[23])
            z_value_o[30:23] <= 8'd0;
          if ($signed(z_u.e) > 10'sd127)
            z_value_o <= {z_u.s, FP_EXP_MAX, 23'd0};
          state <= DONE;
        end

        DONE: begin
          done_strobe_o <= 1'b1;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for the IEEE-754 single multiplier.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [31:0] a_value_i = '0;
  logic [31:0] b_value_i = '0;
  logic        exec_strobe_i = 1'b0;
  logic [31:0] z_value_o;
  logic        done_strobe_o;

  int vectors = 0;
  int miscompares = 0;

  localparam int TMO = 400;

  always #5 clk = ~clk;

  multiplier dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .a_value_i     (a_value_i),
    .b_value_i     (b_value_i),
    .exec_strobe_i (exec_strobe_i),
    .z_value_o     (z_value_o),
    .done_strobe_o (done_strobe_o)
  );

  // Issue one operation and observe result, latency (edges from the strobe
  // edge) and whether done dropped one cycle later. Operands are scrambled
  // after the strobe cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output int lat, output logic one_wide);
    @(negedge clk);
    a_value_i = a; b_value_i = b; exec_strobe_i = 1'b1;
    @(negedge clk);
    exec_strobe_i = 1'b0; a_value_i = 32'h7FC00000; b_value_i = 32'h12345678;
    lat = 1;
    while (done_strobe_o !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    z = z_value_o;
    @(negedge clk);
    one_wide = (done_strobe_o === 1'b0);
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (z_value_o !== 32'd0) begin
      miscompares++; $display("FAIL reset_z got %h want %h", z_value_o, 32'd0);
    end
    vectors++;
    if (done_strobe_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_done got %b want 0", done_strobe_o);
    end
    reset_i = 1'b1;
  endtask

  task automatic test_arith();
    logic [31:0] va [6], vb [6], vz [6];
    logic [31:0] z; int lat; logic w;
    va[0] = 32'h40000000; vb[0] = 32'h40400000; vz[0] = 32'h40C00000; // 2*3
    va[1] = 32'hBFC00000; vb[1] = 32'h40000000; vz[1] = 32'hC0400000; // -1.5*2
    va[2] = 32'h3F800001; vb[2] = 32'h3F800001; vz[2] = 32'h3F800002; // RNE
    va[3] = 32'h3FC00000; vb[3] = 32'h3FC00000; vz[3] = 32'h40100000; // 1.5*1.5
    va[4] = 32'h3F800000; vb[4] = 32'h3F800000; vz[4] = 32'h3F800000; // 1*1
    va[5] = 32'h00400000; vb[5] = 32'h40000000; vz[5] = 32'h00800000; // denorm*2
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], z, lat, w);
      vectors++;
      if (z !== vz[i] || lat >= TMO) begin
        miscompares++;
        $display("FAIL arith[%0d] %h*%h got %h want %h (lat %0d)", i, va[i], vb[i], z, vz[i], lat);
      end
      vectors++;
      if (w !== 1'b1) begin
        miscompares++; $display("FAIL arith_pulse[%0d] done still high one cycle later", i);
      end
`ifndef MULTIPLIER_SEQ_MUL_EN
      if (i == 0 || i == 4) begin
        vectors++;
        if (lat != 13) begin
          miscompares++; $display("FAIL arith_latency[%0d] got %0d want 13", i, lat);
        end
      end
`endif
    end
  endtask

  task automatic test_special();
    logic [31:0] va [5], vb [5], vz [5];
    logic [31:0] z; int lat; logic w;
    va[0] = 32'h7FC00000; vb[0] = 32'h3F800000; vz[0] = 32'hFFC00000; // NaN*1
    va[1] = 32'h7F800000; vb[1] = 32'h00000000; vz[1] = 32'hFFC00000; // inf*0
    va[2] = 32'h00000000; vb[2] = 32'hFF800000; vz[2] = 32'hFFC00000; // 0*-inf
    va[3] = 32'hFF800000; vb[3] = 32'h40000000; vz[3] = 32'hFF800000; // -inf*2
    va[4] = 32'h00000000; vb[4] = 32'hC0400000; vz[4] = 32'h80000000; // 0*-3
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], z, lat, w);
      vectors++;
      if (z !== vz[i] || lat >= TMO) begin
        miscompares++;
        $display("FAIL special[%0d] %h*%h got %h want %h", i, va[i], vb[i], z, vz[i]);
      end
      vectors++;
      if (lat != 4) begin
        miscompares++; $display("FAIL special_latency[%0d] got %0d want 4", i, lat);
      end
    end
  endtask

  task automatic test_overflow_underflow();
    logic [31:0] z; int lat; logic w;
    do_op(32'h7F000000, 32'h7F000000, z, lat, w);
    vectors++;
    if (z !== 32'h7F800000 || lat >= TMO) begin
      miscompares++; $display("FAIL overflow got %h want %h", z, 32'h7F800000);
    end
    do_op(32'h00000001, 32'h3F800000, z, lat, w);
    vectors++;
    if (z !== 32'h00000001 || lat >= TMO) begin
      miscompares++; $display("FAIL underflow got %h want %h", z, 32'h00000001);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] z; int lat; logic w; int seen;
    @(negedge clk);
    a_value_i = 32'h40000000; b_value_i = 32'h40400000; exec_strobe_i = 1'b1;
    @(negedge clk);                 // after edge 1
    exec_strobe_i = 1'b0;
    repeat (6) @(negedge clk);      // after edge 7: sitting in NORMALIZE_0
    reset_i = 1'b0;
    #1;
    vectors++;
    if (z_value_o !== 32'd0 || done_strobe_o !== 1'b0) begin
      miscompares++; $display("FAIL abort_outputs got z=%h done=%b want 0/0", z_value_o, done_strobe_o);
    end
    @(negedge clk);
    reset_i = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_strobe_o === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL abort_no_done got %0d pulses want 0", seen);
    end
    do_op(32'h40000000, 32'h40400000, z, lat, w);
    vectors++;
    if (z !== 32'h40C00000 || lat >= TMO) begin
      miscompares++; $display("FAIL after_reset got %h want %h", z, 32'h40C00000);
    end
  endtask

  task automatic test_busy_strobe();
    int lat; int seen; logic [31:0] z;
    @(negedge clk);
    a_value_i = 32'h40000000; b_value_i = 32'h40400000; exec_strobe_i = 1'b1;
    @(negedge clk);
    exec_strobe_i = 1'b0;
    lat = 1;
    while (done_strobe_o !== 1'b1 && lat < TMO) begin
      // strobe with a NaN operand while busy; must be ignored
      if (lat >= 2 && lat <= 5) begin
        exec_strobe_i = 1'b1; a_value_i = 32'h7FC00000; b_value_i = 32'h3F800000;
      end else begin
        exec_strobe_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    exec_strobe_i = 1'b0;
    z = z_value_o;
    vectors++;
    if (z !== 32'h40C00000 || lat >= TMO) begin
      miscompares++; $display("FAIL busy_strobe got %h want %h (lat %0d)", z, 32'h40C00000, lat);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_strobe_o === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL busy_extra_done got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] z;
    @(negedge clk);
    a_value_i = 32'h40000000; b_value_i = 32'h40400000; exec_strobe_i = 1'b1;
    @(negedge clk);
    exec_strobe_i = 1'b0;
    lat = 1;
    while (done_strobe_o !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    // new request raised while done is still high
    a_value_i = 32'hBFC00000; b_value_i = 32'h40000000; exec_strobe_i = 1'b1;
    vectors++;
    if (z_value_o !== 32'h40C00000 || lat >= TMO) begin
      miscompares++; $display("FAIL b2b_first got %h want %h", z_value_o, 32'h40C00000);
    end
    @(negedge clk);
    exec_strobe_i = 1'b0;
    lat = 1;
    while (done_strobe_o !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    z = z_value_o;
    vectors++;
    if (z !== 32'hC0400000 || lat >= TMO) begin
      miscompares++; $display("FAIL b2b_second got %h want %h", z, 32'hC0400000);
    end
`ifndef MULTIPLIER_SEQ_MUL_EN
    vectors++;
    if (lat != 13) begin
      miscompares++; $display("FAIL b2b_latency got %0d want 13", lat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_overflow_underflow();
    test_reset_abort();
    test_busy_strobe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
